// File: rtl/serial_subtractor_16.sv
// serial_subtractor_16
//   Multi-cycle ripple-borrow subtractor: diff = in1 - in2 - bin, computed
//   DIGIT bits per clock, LSB first, behind a start/ready/done handshake.
//   Results are registered and held until the next operation completes.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request an operation (accepted only while ready)
//   in1    in   minuend, sampled on the accepting edge
//   in2    in   subtrahend, sampled on the accepting edge
//   bin    in   borrow-in, sampled on the accepting edge
//   ready  out  high in IDLE
//   busy   out  high in RUN
//   done   out  one-cycle pulse when diff/bout/ovf are updated
//   diff   out  (in1 - in2 - bin) mod 2^WIDTH
//   bout   out  borrow out of bit WIDTH-1
//   ovf    out  two's-complement overflow of the signed subtraction
module serial_subtractor_16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] res_q, res_d;
  // Operand sign bits are kept aside because the operand registers are
  // shifted out during RUN.
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_diff;
  logic             dig_borrow;
  logic [WIDTH-1:0] res_next;

  // One DIGIT-wide ripple-borrow slice on the low bits of the operand shifters.
  always_comb begin
    dig_diff   = '0;
    dig_borrow = borrow_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dig_diff[i] = a_q[i] ^ b_q[i] ^ dig_borrow;
      dig_borrow  = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & dig_borrow);
    end
    // New digit enters at the top; after N digits digit 0 sits at the LSB.
    res_next = (res_q >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    res_d    = res_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = in1;
          b_d      = in2;
          borrow_d = bin;
          a_msb_d  = in1[WIDTH-1];
          b_msb_d  = in2[WIDTH-1];
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        borrow_d = dig_borrow;
        res_d    = res_next;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = res_next;
          bout_d  = dig_borrow;
          ovf_d   = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      res_q    <= res_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign ovf   = ovf_q;

endmodule
